// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: counter-based RAW hazard detection for the ID stage.
// Each architectural register has a small countdown recording how many more
// cycles its pending result stays unavailable to a reader sitting in ID.
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int WB_LAT   = 2,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2,
  parameter int STAT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      id_src1,
  input  logic [REG_W-1:0]      id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic [REG_W-1:0]      id_dest,
  input  logic                  id_mem_read,
  input  logic                  forward_en,
  output logic                  hazard,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [(2**REG_W)-1:0] busy_vec,
  output logic [STAT_W-1:0]     stall_count
);

  localparam int NUM_REGS = 2 ** REG_W;

  localparam logic [CNT_W-1:0] WB_LAT_C   = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] ALU_LAT_C  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec_q, busy_vec_d;
  logic [STAT_W-1:0]   stall_count_q, stall_count_d;

  logic [CNT_W-1:0] src1_cnt;
  logic [CNT_W-1:0] src2_cnt;
  logic             hit1;
  logic             hit2;
  logic             issue;
  logic [CNT_W-1:0] lat;

  // Hazard check against the current counts; the second source only counts
  // when the instruction actually reads it, and a flushed slot never stalls.
  always_comb begin
    src1_cnt     = cnt_q[id_src1];
    src2_cnt     = id_two_src ? cnt_q[id_src2] : '0;
    hit1         = (src1_cnt != '0);
    hit2         = id_two_src && (cnt_q[id_src2] != '0);
    hazard       = id_valid && !flush && (hit1 || hit2);
    stall_cycles = (src1_cnt > src2_cnt) ? src1_cnt : src2_cnt;
    issue        = id_valid && !flush && !hazard && id_wb_en;
    if (forward_en) begin
      lat = id_mem_read ? LOAD_LAT_C : ALU_LAT_C;
    end else begin
      lat = WB_LAT_C;
    end
  end

  // Next counts: the issuing writer overwrites its destination (youngest
  // wins, even with a shorter latency); every other entry decays toward zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
      if (issue && (id_dest == REG_W'(r))) begin
        cnt_d[r] = lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
      busy_vec_d[r] = (cnt_d[r] != '0);
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STAT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_vec_q    <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_vec_q    <= busy_vec_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_vec    = busy_vec_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan sequences plus randomized traffic,
// checked against a ready-time reference model through an expectation queue.
module tb_hazard_scoreboard;

  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int WB_LAT   = 2;
  localparam int ALU_LAT  = 0;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 2;
  localparam int STAT_W   = 4;
  localparam int STAT_MAX = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                id_valid;
  logic [REG_W-1:0]    id_src1;
  logic [REG_W-1:0]    id_src2;
  logic                id_two_src;
  logic                id_wb_en;
  logic [REG_W-1:0]    id_dest;
  logic                id_mem_read;
  logic                forward_en;
  logic                hazard;
  logic [CNT_W-1:0]    stall_cycles;
  logic [NUM_REGS-1:0] busy_vec;
  logic [STAT_W-1:0]   stall_count;

  typedef struct {
    int hz;
    int sc;
    int busy;
    int stat;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: absolute cycle at which each register's result becomes
  // readable, plus the saturating stall statistic.
  int ready_at [NUM_REGS];
  int stat_m;
  int t_now;

  hazard_scoreboard #(
    .REG_W   (REG_W),
    .WB_LAT  (WB_LAT),
    .ALU_LAT (ALU_LAT),
    .LOAD_LAT(LOAD_LAT),
    .CNT_W   (CNT_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_mem_read (id_mem_read),
    .forward_en  (forward_en),
    .hazard      (hazard),
    .stall_cycles(stall_cycles),
    .busy_vec    (busy_vec),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic int remaining(input int r);
    return (ready_at[r] > t_now) ? (ready_at[r] - t_now) : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0d)", name, act, req, t_now);
    end
  endtask

  // One ID cycle: drive inputs after the edge, push the model's expectation
  // for this cycle, optionally check spec constants, then advance the model.
  task automatic applyStimulus(input logic v, input logic fl, input int s1, input int s2,
                               input logic two, input logic wb, input int dst,
                               input logic mem, input logic fwd, input logic rs,
                               input int exp_hz, input int exp_sc);
    exp_t e;
    int   r1, r2, lat, busy;
    logic hz, iss;
    @(posedge clk);
    #1;
    rst         = rs;
    flush       = fl;
    id_valid    = v;
    id_src1     = REG_W'(s1);
    id_src2     = REG_W'(s2);
    id_two_src  = two;
    id_wb_en    = wb;
    id_dest     = REG_W'(dst);
    id_mem_read = mem;
    forward_en  = fwd;

    r1   = remaining(s1);
    r2   = two ? remaining(s2) : 0;
    hz   = v && !fl && (r1 != 0 || r2 != 0);
    busy = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (remaining(r) != 0) busy |= (1 << r);
    end
    e.hz   = int'(hz);
    e.sc   = (r1 > r2) ? r1 : r2;
    e.busy = busy;
    e.stat = stat_m;
    exp_q.push_back(e);

    #1;
    if (exp_hz >= 0) checkOutput("hazard_directed", int'(hazard), exp_hz);
    if (exp_sc >= 0) checkOutput("stall_cycles_directed", int'(stall_cycles), exp_sc);

    iss = v && !fl && !hz && wb;
    lat = fwd ? (mem ? LOAD_LAT : ALU_LAT) : WB_LAT;
    if (rs) begin
      for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
      stat_m = 0;
    end else begin
      if (hz && stat_m < STAT_MAX) stat_m++;
      if (iss) ready_at[dst] = t_now + 1 + lat;
    end
    t_now++;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, -1);
  endtask

  // Monitor: every cycle the DUT presents a result; compare it with the
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hazard", int'(hazard), e.hz);
        checkOutput("stall_cycles", int'(stall_cycles), e.sc);
        checkOutput("busy_vec", int'(busy_vec), e.busy);
        checkOutput("stall_count", int'(stall_count), e.stat);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s1, s2, dst;
    for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    stat_m = 0;
    t_now  = 0;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
    id_two_src = 1'b0; id_wb_en = 1'b0; id_dest = '0; id_mem_read = 1'b0;
    forward_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    idle();
    checkOutput("reset_busy_vec", int'(busy_vec), 0);
    checkOutput("reset_stall_count", int'(stall_count), 0);

    // No forwarding, back-to-back dependency on r3.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 2);
    applyStimulus(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1);
    applyStimulus(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle();
    checkOutput("nofwd_stall_count", int'(stall_count), 2);

    // Forwarding: ALU result never blocks, load blocks one cycle.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1);
    applyStimulus(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Second-source gating with r7 busy.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1, 7, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1);
    idle();

    // Youngest writer overwrites a longer pending count.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("overwrite_busy2", int'(busy_vec[2]), 0);

    // Flush: no stall, no issue, pending counts keep decaying.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 6, 0, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 0, 2);
    applyStimulus(1'b1, 1'b0, 9, 6, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1);
    idle();

    // Reset in the middle of a countdown.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1, 2);
    applyStimulus(1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("rst_busy_vec", int'(busy_vec), 0);
    checkOutput("rst_stall_count", int'(stall_count), 0);

    // Long stretch of self-dependent no-forward writers to saturate the stat.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, -1, -1);
    end
    idle();
    checkOutput("stall_count_saturated", int'(stall_count), STAT_MAX);

    // Randomized traffic biased toward a few registers to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      s1  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(12, 15);
      s2  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(12, 15);
      dst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(12, 15);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                    s1, s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    dst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0), -1, -1);
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, counter-based hazard unit for the in-order pipeline's ID stage. One countdown entry per architectural register records how many more cycles its pending result stays unavailable to a reader in ID. `hazard` is raised when either source of the ID instruction hits a non-zero entry. Latencies are configurable for ALU, load and no-forward modes, and a saturating stall counter is provided for performance monitoring.

## Interface
Parameters:
- `REG_W`, 4: register address width; `NUM_REGS = 2**REG_W` entries.
- `WB_LAT`, 2: cycles a result is unavailable when forwarding is disabled (EXE + MEM).
- `ALU_LAT`, 0: cycles an ALU result is unavailable with forwarding enabled.
- `LOAD_LAT`, 1: cycles a load result is unavailable with forwarding enabled.
- `CNT_W`, 2: entry width; must hold max(WB_LAT, ALU_LAT, LOAD_LAT).
- `STAT_W`, 16: stall statistics counter width.

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash the ID instruction this cycle.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`  in  REG_W  first source register.
- `id_src2`  in  REG_W  second source register.
- `id_two_src`  in  1  `id_src2` is used.
- `id_wb_en`  in  1  ID instruction writes `id_dest`.
- `id_dest`  in  REG_W  destination register.
- `id_mem_read`  in  1  ID instruction is a load.
- `forward_en`  in  1  forwarding unit is active (mode select).
- `hazard`  out  1  stall IF/ID this cycle (combinational).
- `stall_cycles`  out  CNT_W  max remaining count over the used sources (combinational).
- `busy_vec`  out  NUM_REGS  bit r = (cnt[r] != 0), registered.
- `stall_count`  out  STAT_W  number of cycles with `hazard`=1, saturating.

## Operation
- State: `cnt[0..NUM_REGS-1]` (CNT_W each) and `stall_count`.
- Hit rules:
  - `hit1 = cnt[id_src1] != 0`.
  - `hit2 = id_two_src && cnt[id_src2] != 0`.
- Hazard: `hazard = id_valid && !flush && (hit1 || hit2)`.
- Stall cycles: `stall_cycles` = max of `cnt[id_src1]` and (`id_two_src` ? `cnt[id_src2]` : 0). It is driven regardless of `id_valid`.
- Issue: `issue = id_valid && !flush && !hazard && id_wb_en`.
- Issue latency: `lat = forward_en ? (id_mem_read ? LOAD_LAT : ALU_LAT) : WB_LAT`.
- Per-cycle update, all entries in parallel:
  - If `issue` and r == `id_dest`: `cnt[r] <= lat`. The youngest writer overwrites, even if lat is smaller than the current count.
  - Otherwise: `cnt[r] <= (cnt[r] == 0) ? 0 : cnt[r] - 1`.
- Flush: the ID instruction is neither checked nor issued. Entries keep counting down, because already-issued instructions still complete.
- Changing `forward_en` affects only new issues; existing counts are not rescaled.
- `stall_count` increments when `hazard`=1 and holds at all-ones.
- No register is special-cased; r15 is tracked like any other.

## Timing
- Reset (synchronous): all `cnt` = 0, `busy_vec` = 0, `stall_count` = 0.
  - `hazard` and `stall_cycles` are 0 in the cycle after reset, and whenever no entries are busy.
- `hazard` and `stall_cycles` are combinational from the current `cnt` and the ID inputs.
- `busy_vec` and `stall_count` are registered, so they reflect issues and stalls from the previous edge.
- An instruction issued at edge N is visible at N+1 as `cnt = lat`. It blocks dependents for exactly `lat` cycles; lat = 0 never blocks.
- Simultaneous issue to a register r while r is decrementing: the issue wins.
- Source and destination of the same instruction both equal r: the check uses the old `cnt`. The new value is applied only if there is no hazard.
- `rst` asserted mid-countdown clears every entry at that edge; the cycle after shows `hazard`=0.

## Test plan
- No forwarding, back-to-back dependency:
  - Stimulus: issue `wb_en`=1, dest=3; next cycle src1=3.
  - Required: `hazard`=1 for 2 cycles with `stall_cycles` 2 then 1; third cycle `hazard`=0; `stall_count`=2.
- Forwarding, ALU then load:
  - Stimulus: `forward_en`=1; ALU writing r5 then reader of r5.
  - Required: `hazard`=0.
  - Stimulus: load writing r5 then reader of r5.
  - Required: `hazard`=1 for exactly 1 cycle.
- `id_two_src` gating:
  - Stimulus: r7 busy; src1=1, src2=7, `id_two_src`=0.
  - Required: `hazard`=0.
  - Stimulus: same with `id_two_src`=1.
  - Required: `hazard`=1.
- Overwrite:
  - Stimulus: no-forward issue to r2 (cnt=2); next cycle forwarded ALU issue to r2 with no source conflict.
  - Required: `cnt[2]`=0 and `busy_vec[2]`=0 after that edge.
- Flush and reset:
  - Stimulus: flush with a dependent ID instruction.
  - Required: `hazard`=0, no issue, counts still decrement.
  - Stimulus: `rst` while `cnt[4]`=2.
  - Required: next cycle `busy_vec`=0 and `stall_count`=0.
- Saturation:
  - Stimulus: `STAT_W`=4; hold a permanent stall for 20 cycles.
  - Required: `stall_count` stops at 15.
